// File: rtl/serial_subtractor_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
// Holds the FSM state encoding and the bit-counter width function.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  // Returns the smallest w with 2**w >= width (minimum 1).
  function automatic int cnt_width(input int width);
    int w;
    w = 1;
    while ((1 << w) < width) w++;
    return w;
  endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Request/result bundle between a requester and the serial subtractor.
interface serial_subtractor_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Bin;
  logic [WIDTH-1:0] Diff;
  logic             Bout;
  logic             busy;
  logic             done;

  modport master (
    output start, A, B, Bin,
    input  Diff, Bout, busy, done
  );

  modport slave (
    input  start, A, B, Bin,
    output Diff, Bout, busy, done
  );
endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor: D = A - B - Bin, Bout set when a borrow is needed.
module full_subtractor (
  input  logic A,
  input  logic B,
  input  logic Bin,
  output logic D,
  output logic Bout
);

  assign D    = A ^ B ^ Bin;
  assign Bout = (~A & B) | (~(A ^ B) & Bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes A - B - Bin one bit per cycle, LSB first,
// using a single full_subtractor cell and registered result outputs.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  serial_subtractor_if.slave bus
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [WIDTH-1:0] diff_q;
  logic             brw;
  logic             bout_q;
  logic [CW-1:0]    cnt;
  logic             d_bit;
  logic             brw_next;
  logic             load;
  logic             step;
  logic             last;

  full_subtractor u_fs (
    .A    (a_sr[0]),
    .B    (b_sr[0]),
    .Bin  (brw),
    .D    (d_bit),
    .Bout (brw_next)
  );

  assign last = (cnt == CW'(WIDTH - 1));

  always_comb begin
    next_state = state;
    load       = 1'b0;
    step       = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          load       = 1'b1;
          next_state = BUSY;
        end
      end
      BUSY: begin
        step = 1'b1;
        if (last) next_state = DONE;
      end
      DONE: begin
        if (bus.start) begin
          load       = 1'b1;
          next_state = BUSY;
        end else begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Result shifts in from the MSB side; Diff/Bout only update on the last bit
  // so the outputs never expose a partially built difference.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      brw    <= 1'b0;
      cnt    <= '0;
      diff_q <= '0;
      bout_q <= 1'b0;
    end else if (load) begin
      a_sr   <= bus.A;
      b_sr   <= bus.B;
      brw    <= bus.Bin;
      res_sr <= '0;
      cnt    <= '0;
    end else if (step) begin
      a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
      b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
      brw    <= brw_next;
      res_sr <= {d_bit, res_sr[WIDTH-1:1]};
      if (!last) cnt <= cnt + 1'b1;
      if (last) begin
        diff_q <= {d_bit, res_sr[WIDTH-1:1]};
        bout_q <= brw_next;
      end
    end
  end

  assign bus.Diff = diff_q;
  assign bus.Bout = bout_q;
  assign bus.busy = (state == BUSY);
  assign bus.done = (state == DONE);

endmodule
